i2c_byte_rx: RTL and testbench

Byte-level I2C target receive engine sitting directly downstream of the SCL/SDA sampler. It consumes the sampler's synchronized SCL/SDA levels and its START/STOP pulses, matches the 7-bit target address, shifts in write-data bytes MSB-first and drives ACK/NACK via an SDA pull-down enable. Received bytes go to the hasher through a one-deep valid/ready register. Write transactions only; read-direction addresses are NACKed.

---
 rtl/i2c_byte_rx.sv | 155 +++++++++++++++
 tb/tb_i2c_byte_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_rx.sv
// I2C target receive engine: address match, MSB-first write-data shift, ACK/NACK
// via SDA pull-down enable, one-deep valid/ready output register.
module i2c_byte_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_sync,
  input  logic       sda_sync,
  input  logic       start_det,
  input  logic       stop_det,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addr_match,
  output logic       frame_end,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_q;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        slot_q, slot_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        addr_match_q, addr_match_d;
  logic        frame_end_q, frame_end_d;
  logic        overrun_q, overrun_d;

  logic        scl_rise, scl_fall;
  logic [7:0]  byte_w;

  assign scl_rise = scl_sync & ~scl_q;
  assign scl_fall = ~scl_sync & scl_q;
  assign byte_w   = {shift_q[6:0], sda_sync};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      scl_q        <= 1'b1;
      shift_q      <= '0;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      slot_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      frame_end_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_q        <= scl_sync;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      slot_q       <= slot_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      frame_end_q  <= frame_end_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    ack_d        = ack_q;
    slot_d       = slot_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    addr_match_d = addr_match_q;
    frame_end_d  = 1'b0;
    overrun_d    = 1'b0;
    // Output register drains independently of bus framing; a load below overrides.
    rx_valid_d   = rx_valid_q & ~rx_ready;

    if (start_det) begin
      state_d      = ADDR;
      cnt_d        = '0;
      shift_d      = '0;
      sda_oe_d     = 1'b0;
      frame_end_d  = addr_match_q;
      addr_match_d = 1'b0;
    end else if (stop_det) begin
      state_d      = IDLE;
      sda_oe_d     = 1'b0;
      frame_end_d  = addr_match_q;
      addr_match_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_d = byte_w;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              slot_d = 1'b0;
              if (state_q == ADDR) begin
                ack_d        = (byte_w[7:1] == TARGET_ADDR) && !byte_w[0];
                addr_match_d = ack_d;
                state_d      = ADDR_ACK;
              end else begin
                if (!rx_valid_q || rx_ready) begin
                  rx_data_d  = byte_w;
                  rx_valid_d = 1'b1;
                  ack_d      = 1'b1;
                end else begin
                  ack_d      = 1'b0;
                  overrun_d  = 1'b1;
                end
                state_d = DATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // First fall opens the ACK slot, second fall closes it.
          if (scl_fall) begin
            if (!slot_q) begin
              sda_oe_d = ack_q;
              slot_d   = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ack_q ? DATA : IGNORE;
            end
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_oe     = sda_oe_q;
    rx_data    = rx_data_q;
    rx_valid   = rx_valid_q;
    addr_match = addr_match_q;
    frame_end  = frame_end_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_i2c_byte_rx.sv
// Bench for i2c_byte_rx: bit-level bus driver, scoreboard of accepted bytes,
// pulse counters for frame_end/overrun.
module tb_i2c_byte_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_sync, sda_sync, start_det, stop_det, rx_ready;
  logic       sda_oe, rx_valid, addr_match, frame_end, overrun;
  logic [7:0] rx_data;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_exp = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  i2c_byte_rx #(.TARGET_ADDR(7'h2A)) dut (
    .clk(clk), .reset(reset), .scl_sync(scl_sync), .sda_sync(sda_sync),
    .start_det(start_det), .stop_det(stop_det), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .addr_match(addr_match), .frame_end(frame_end), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_end) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        chk("pop_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    scl_sync = 1'b1; sda_sync = 1'b1;
    tick(2);
    start_det = 1'b1; tick(1); start_det = 1'b0;
    scl_sync = 1'b0;
    tick(2);
  endtask

  task automatic bus_stop();
    scl_sync = 1'b1;
    tick(2);
    stop_det = 1'b1; tick(1); stop_det = 1'b0;
    tick(2);
  endtask

  task automatic send_bit(input logic b);
    sda_sync = b;
    tick(3);
    scl_sync = 1'b1;
    tick(4);
    scl_sync = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_sync = 1'b1;
    tick(3);
    scl_sync = 1'b1;
    tick(2);
    chk({tag, "_ack"}, sda_oe, exp_ack);
    tick(2);
    scl_sync = 1'b0;
    tick(3);
    chk({tag, "_rel"}, sda_oe, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(1); n++; end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; scl_sync = 1'b1; sda_sync = 1'b1;
    start_det = 1'b0; stop_det = 1'b0; rx_ready = 1'b1;
    tick(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_addr_match", addr_match, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick(3);

    // Address match with two data bytes
    bus_start();
    send_byte(8'h54, 1, "m_addr");
    chk("m_addr_match", addr_match, 1);
    exp_q.push_back(8'hDE); send_byte(8'hDE, 1, "m_de");
    exp_q.push_back(8'hAD); send_byte(8'hAD, 1, "m_ad");
    bus_stop();
    fe_exp++;
    chk("m_frame_end", fe_cnt, fe_exp);
    chk("m_addr_match_off", addr_match, 0);
    drain("m");
    chk("m_last_data", rx_data, 8'hAD);

    // Reset mid-address: outputs clear asynchronously
    bus_start();
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h54 >> i));
    #1 reset = 1'b1;
    #1;
    chk("rm_rx_data", rx_data, 0);
    chk("rm_sda_oe", sda_oe, 0);
    chk("rm_rx_valid", rx_valid, 0);
    chk("rm_addr_match", addr_match, 0);
    scl_sync = 1'b1; sda_sync = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    bus_start();
    send_byte(8'h54, 1, "rm_addr");
    chk("rm_match", addr_match, 1);
    bus_stop();
    fe_exp++;
    chk("rm_frame_end", fe_cnt, fe_exp);

    // Address miss and read direction
    bus_start();
    send_byte(8'h56, 0, "miss_addr");
    chk("miss_match", addr_match, 0);
    send_byte(8'h77, 0, "miss_data");
    bus_stop();
    bus_start();
    send_byte(8'h55, 0, "rd_addr");
    chk("rd_match", addr_match, 0);
    send_byte(8'h99, 0, "rd_data");
    bus_stop();
    chk("miss_frame_end", fe_cnt, fe_exp);
    chk("miss_rx_valid", rx_valid, 0);

    // Overrun
    rx_ready = 1'b0;
    bus_start();
    send_byte(8'h54, 1, "ov_addr");
    exp_q.push_back(8'h11); send_byte(8'h11, 1, "ov_11");
    chk("ov_valid", rx_valid, 1);
    send_byte(8'h22, 0, "ov_22");
    chk("ov_pulses", ov_cnt, 1);
    chk("ov_data_kept", rx_data, 8'h11);
    send_byte(8'h33, 0, "ov_33");
    chk("ov_pulses_after", ov_cnt, 1);
    bus_stop();
    fe_exp++;
    chk("ov_frame_end", fe_cnt, fe_exp);
    chk("ov_valid_survives", rx_valid, 1);
    rx_ready = 1'b1;
    drain("ov");

    // Repeated START
    bus_start();
    send_byte(8'h54, 1, "rs_addr1");
    exp_q.push_back(8'h01); send_byte(8'h01, 1, "rs_01");
    bus_start();
    fe_exp++;
    chk("rs_frame_end", fe_cnt, fe_exp);
    send_byte(8'h54, 1, "rs_addr2");
    exp_q.push_back(8'h02); send_byte(8'h02, 1, "rs_02");
    bus_stop();
    fe_exp++;
    chk("rs_frame_end_stop", fe_cnt, fe_exp);
    drain("rs");

    // Simultaneous START and STOP while matched: START wins
    bus_start();
    send_byte(8'h54, 1, "ss_addr");
    scl_sync = 1'b1;
    tick(2);
    start_det = 1'b1; stop_det = 1'b1;
    tick(1);
    start_det = 1'b0; stop_det = 1'b0;
    scl_sync = 1'b0;
    tick(2);
    fe_exp++;
    chk("ss_frame_end", fe_cnt, fe_exp);
    chk("ss_addr_match", addr_match, 0);
    chk("ss_sda_oe", sda_oe, 0);
    send_byte(8'h54, 1, "ss_addr2");
    exp_q.push_back(8'h5A); send_byte(8'h5A, 1, "ss_5a");
    bus_stop();
    fe_exp++;
    chk("ss_frame_end_stop", fe_cnt, fe_exp);
    drain("ss");
    chk("ov_total", ov_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
